k3_processor: RTL and testbench

- Parametrised successor to the two-register, 10-bit-instruction processor.
- Multi-cycle core with a register file of NREG general registers and a 4-function ALU.
- Conditional and unconditional branches, flag registers, an output register, and halt.
- Data memory is reached through a req/ack handshake, so it may take any number of wait cycles.
- Sits between an instruction ROM (combinational read, addressed by romaddress) and a data RAM.

---
 rtl/k3_pkg.sv | 52 +++++
 rtl/k3_alu.sv | 38 +++
 rtl/k3_processor.sv | 206 ++++++++++++++++++++
 tb/tb_k3_processor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/k3_pkg.sv
// Shared types and instruction-field helpers for the k3 multi-cycle core.
package k3_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_JMP  = 4'd8,
        OP_JC   = 4'd9,
        OP_JZ   = 4'd10,
        OP_OUT  = 4'd11,
        OP_HALT = 4'd12,
        OP_CALL = 4'd13,
        OP_RET  = 4'd14,
        OP_RSV  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_fn_e;

    localparam int OPW = 4;

    // Instruction layout, MSB first: op | rd | rs | imm.
    function automatic int inst_width(input int rw, input int immw);
        return OPW + 2 * rw + immw;
    endfunction

    function automatic int rd_lsb(input int rw, input int immw);
        return immw + rw;
    endfunction

    function automatic int rs_lsb(input int immw);
        return immw;
    endfunction

endpackage

// File: rtl/k3_alu.sv
// Combinational N-bit ALU: add, subtract (carry = borrow), and, or.
module k3_alu
    import k3_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_fn,
    output logic [N-1:0] o_result,
    output logic         o_carry,
    output logic         o_zero
);

    logic [N:0] w_sum;

    // The extra top bit doubles as carry for ADD and borrow for SUB.
    always_comb begin
        w_sum   = '0;
        o_carry = 1'b0;
        case (alu_fn_e'(i_fn))
            ALU_ADD: begin
                w_sum   = {1'b0, i_a} + {1'b0, i_b};
                o_carry = w_sum[N];
            end
            ALU_SUB: begin
                w_sum   = {1'b0, i_a} - {1'b0, i_b};
                o_carry = w_sum[N];
            end
            ALU_AND: w_sum = {1'b0, i_a & i_b};
            default: w_sum = {1'b0, i_a | i_b};
        endcase
    end

    assign o_result = w_sum[N-1:0];
    assign o_zero   = (w_sum[N-1:0] == '0);

endmodule

// File: rtl/k3_processor.sv
// k3 multi-cycle processor: FETCH/EXEC/MEM/HALT core with req/ack data memory.
// Optional CALL/RET with a single link register when K3_CALL_EN is defined.
module k3_processor
    import k3_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREG = 4,
    parameter int IMMW = 5
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [inst_width($clog2(NREG), IMMW)-1:0]    inst,
    output logic [IMMW-1:0]                              romaddress,
    output logic                                         mem_req,
    output logic                                         mem_we,
    output logic [IMMW-1:0]                              mem_addr,
    output logic [N-1:0]                                 mem_wdata,
    input  logic [N-1:0]                                 mem_rdata,
    input  logic                                         mem_ack,
    output logic [N-1:0]                                 regO,
    output logic                                         flag_c,
    output logic                                         flag_z,
    output logic                                         halted
);

    localparam int RW     = $clog2(NREG);
    localparam int IW     = inst_width(RW, IMMW);
    localparam int RD_LSB = rd_lsb(RW, IMMW);
    localparam int RS_LSB = rs_lsb(IMMW);

    state_e          r_state;
    state_e          w_state_next;
    logic [IW-1:0]   r_ir;
    logic [IMMW-1:0] r_pc;
    logic [N-1:0]    r_rego;
    logic            r_c;
    logic            r_z;
    logic            r_mem_req;

    logic [3:0]      w_op_bits;
    opcode_e         w_op;
    logic [RW-1:0]   w_rd;
    logic [RW-1:0]   w_rs;
    logic [IMMW-1:0] w_imm;
    logic [N-1:0]    w_regs [NREG];
    logic [N-1:0]    w_rd_val;
    logic [N-1:0]    w_rs_val;
    logic [1:0]      w_alu_fn;
    logic [N-1:0]    w_alu_result;
    logic            w_alu_carry;
    logic            w_alu_zero;

    logic            w_ir_we;
    logic            w_pc_we;
    logic [IMMW-1:0] w_pc_next;
    logic [IMMW-1:0] w_pc_inc;
    logic            w_reg_we;
    logic [N-1:0]    w_reg_wdata;
    logic            w_flag_we;
    logic            w_rego_we;
`ifdef K3_CALL_EN
    logic [IMMW-1:0] r_link;
    logic            w_link_we;
`endif

    assign w_op_bits = r_ir[IW-1 -: 4];
    assign w_op      = opcode_e'(w_op_bits);
    assign w_rd      = r_ir[RD_LSB +: RW];
    assign w_rs      = r_ir[RS_LSB +: RW];
    assign w_imm     = r_ir[IMMW-1:0];
    assign w_rd_val  = w_regs[w_rd];
    assign w_rs_val  = w_regs[w_rs];
    assign w_pc_inc  = r_pc + IMMW'(1);
    // Opcodes 2..5 map onto ALU functions 0..3.
    assign w_alu_fn  = w_op_bits[1:0] - 2'd2;

    k3_alu #(.N(N)) u_alu (
        .i_a      (w_rd_val),
        .i_b      (w_rs_val),
        .i_fn     (w_alu_fn),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: w_state_next = EXEC;
            EXEC: begin
                if (w_op == OP_LD || w_op == OP_ST) w_state_next = MEM;
                else if (w_op == OP_HALT)           w_state_next = HALT;
                else                                w_state_next = FETCH;
            end
            MEM:     if (mem_ack) w_state_next = FETCH;
            default: w_state_next = HALT;
        endcase
    end

    // FSM outputs: datapath strobes for the current state/opcode
    always_comb begin
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_next   = w_pc_inc;
        w_reg_we    = 1'b0;
        w_reg_wdata = w_alu_result;
        w_flag_we   = 1'b0;
        w_rego_we   = 1'b0;
        halted      = (r_state == HALT);
`ifdef K3_CALL_EN
        w_link_we   = 1'b0;
`endif
        case (r_state)
            FETCH: w_ir_we = 1'b1;
            EXEC: begin
                w_pc_we = 1'b1;
                case (w_op)
                    OP_LDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = N'(w_imm);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        w_reg_we  = 1'b1;
                        w_flag_we = 1'b1;
                    end
                    OP_LD, OP_ST: w_pc_we = 1'b0;
                    OP_JMP:       w_pc_next = w_imm;
                    OP_JC:        if (r_c) w_pc_next = w_imm;
                    OP_JZ:        if (r_z) w_pc_next = w_imm;
                    OP_OUT:       w_rego_we = 1'b1;
`ifdef K3_CALL_EN
                    OP_CALL: begin
                        w_link_we = 1'b1;
                        w_pc_next = w_imm;
                    end
                    OP_RET:       w_pc_next = r_link;
`endif
                    default: ;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    w_pc_we     = 1'b1;
                    w_reg_we    = (w_op == OP_LD);
                    w_reg_wdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Each register owns its flop so rd and rs reads always see pre-edge values.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [N-1:0] r_q;
        always_ff @(posedge clk) begin
            if (reset)                                 r_q <= '0;
            else if (w_reg_we && (w_rd == RW'(gi)))    r_q <= w_reg_wdata;
        end
        assign w_regs[gi] = r_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir      <= '0;
            r_pc      <= '0;
            r_rego    <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_mem_req <= 1'b0;
        end else begin
            if (w_ir_we)   r_ir   <= inst;
            if (w_pc_we)   r_pc   <= w_pc_next;
            if (w_rego_we) r_rego <= w_rd_val;
            if (w_flag_we) begin
                r_c <= w_alu_carry;
                r_z <= w_alu_zero;
            end
            r_mem_req <= (w_state_next == MEM);
        end
    end

`ifdef K3_CALL_EN
    always_ff @(posedge clk) begin
        if (reset)          r_link <= '0;
        else if (w_link_we) r_link <= w_pc_inc;
    end
`endif

    // Address, direction and data come from the held IR so they stay stable in MEM.
    assign romaddress = r_pc;
    assign mem_req    = r_mem_req;
    assign mem_we     = (w_op == OP_ST);
    assign mem_addr   = w_imm;
    assign mem_wdata  = w_rd_val;
    assign regO       = r_rego;
    assign flag_c     = r_c;
    assign flag_z     = r_z;

endmodule

// File: tb/tb_k3_processor.sv
// Directed, table-driven bench for k3_processor (N=8, NREG=4, IMMW=5).
// Covers CALL/RET when K3_CALL_EN is defined, NOP behaviour for 13/14 otherwise.
module tb_k3_processor;
    import k3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] inst;
    logic [4:0]  romaddress;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  regO;
    logic        flag_c;
    logic        flag_z;
    logic        halted;

    logic [12:0] rom [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    // memory responder: ack after mem_wait cycles of mem_req, gated by ack_en
    int          mem_wait = 0;
    bit          ack_en   = 1'b1;
    int          wait_cnt = 0;
    int          st_cycles = 0;
    int          ld_cycles = 0;
    logic [4:0]  st_addr  = '0;
    logic [7:0]  st_data  = '0;
    bit          st_pc_bad = 1'b0;

    typedef struct {
        int         cycles;
        int         wt;
        logic [4:0] pc;
        logic [7:0] rego;
        logic       c;
        logic       z;
    } vec_t;

    vec_t va[$];

    k3_processor #(.N(8), .NREG(4), .IMMW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .romaddress (romaddress),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .regO       (regO),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign inst    = rom[romaddress];
    assign mem_ack = mem_req && ack_en && (wait_cnt >= mem_wait);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    always @(negedge clk) begin
        if (mem_req && mem_we) begin
            st_cycles = st_cycles + 1;
            st_addr   = mem_addr;
            st_data   = mem_wdata;
            if (romaddress != 5'd14) st_pc_bad = 1'b1;
        end
        if (mem_req && !mem_we) ld_cycles = ld_cycles + 1;
    end

    function automatic logic [12:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [4:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 13'h0;
    endtask

    task automatic run_table();
        for (int i = 0; i < va.size(); i++) begin
            mem_wait = va[i].wt;
            step(va[i].cycles);
            $display("step %0d: pc=%0d regO=%02h C=%0b Z=%0b", i, romaddress, regO, flag_c, flag_z);
            chk($sformatf("step%0d_pc", i),   32'(romaddress), 32'(va[i].pc));
            chk($sformatf("step%0d_regO", i), 32'(regO),       32'(va[i].rego));
            chk($sformatf("step%0d_C", i),    32'(flag_c),     32'(va[i].c));
            chk($sformatf("step%0d_Z", i),    32'(flag_z),     32'(va[i].z));
        end
    endtask

    initial begin
        mem_rdata = 8'hA5;
        reset     = 1'b1;

        // ---------------- program A: ALU, flags, branches, memory, wrap ----------
        clear_rom();
        rom[0]  = enc(OP_LDI, 2'd1, 2'd0, 5'd5);
        rom[1]  = enc(OP_LDI, 2'd2, 2'd0, 5'd3);
        rom[2]  = enc(OP_ADD, 2'd1, 2'd2, 5'd0);
        rom[3]  = enc(OP_OUT, 2'd1, 2'd0, 5'd0);
        rom[4]  = enc(OP_LDI, 2'd1, 2'd0, 5'd3);
        rom[5]  = enc(OP_LDI, 2'd2, 2'd0, 5'd5);
        rom[6]  = enc(OP_SUB, 2'd1, 2'd2, 5'd0);
        rom[7]  = enc(OP_OUT, 2'd1, 2'd0, 5'd0);
        rom[8]  = enc(OP_JC,  2'd0, 2'd0, 5'd20);
        rom[20] = enc(OP_SUB, 2'd1, 2'd1, 5'd0);
        rom[21] = enc(OP_JC,  2'd0, 2'd0, 5'd2);
        rom[22] = enc(OP_JZ,  2'd0, 2'd0, 5'd10);
        rom[10] = enc(OP_LDI, 2'd1, 2'd0, 5'd7);
        rom[11] = enc(OP_AND, 2'd1, 2'd2, 5'd0);
        rom[12] = enc(OP_JZ,  2'd0, 2'd0, 5'd3);
        rom[13] = enc(OP_OUT, 2'd1, 2'd0, 5'd0);
        rom[14] = enc(OP_ST,  2'd2, 2'd0, 5'd9);
        rom[15] = enc(OP_LD,  2'd3, 2'd0, 5'd9);
        rom[16] = enc(OP_OUT, 2'd3, 2'd0, 5'd0);
        rom[17] = enc(OP_JMP, 2'd0, 2'd0, 5'd24);
        rom[24] = enc(OP_LDI, 2'd0, 2'd0, 5'd16);
        rom[25] = enc(OP_OR,  2'd0, 2'd3, 5'd0);
        rom[26] = enc(OP_OUT, 2'd0, 2'd0, 5'd0);
        rom[27] = enc(OP_ADD, 2'd0, 2'd0, 5'd0);
        rom[28] = enc(OP_JMP, 2'd0, 2'd0, 5'd31);

        step(2);
        chk("rst_pc",     32'(romaddress), 32'd0);
        chk("rst_regO",   32'(regO),       32'd0);
        chk("rst_C",      32'(flag_c),     32'd0);
        chk("rst_Z",      32'(flag_z),     32'd0);
        chk("rst_halted", 32'(halted),     32'd0);
        chk("rst_memreq", 32'(mem_req),    32'd0);
        reset = 1'b0;

        va.delete();
        va.push_back('{2, 0, 5'd1,  8'h00, 1'b0, 1'b0}); // LDI r1,5
        va.push_back('{2, 0, 5'd2,  8'h00, 1'b0, 1'b0}); // LDI r2,3
        va.push_back('{2, 0, 5'd3,  8'h00, 1'b0, 1'b0}); // ADD -> 8
        va.push_back('{2, 0, 5'd4,  8'h08, 1'b0, 1'b0}); // OUT r1
        va.push_back('{2, 0, 5'd5,  8'h08, 1'b0, 1'b0}); // LDI r1,3
        va.push_back('{2, 0, 5'd6,  8'h08, 1'b0, 1'b0}); // LDI r2,5
        va.push_back('{2, 0, 5'd7,  8'h08, 1'b1, 1'b0}); // SUB -> FE, borrow
        va.push_back('{2, 0, 5'd8,  8'hFE, 1'b1, 1'b0}); // OUT r1
        va.push_back('{2, 0, 5'd20, 8'hFE, 1'b1, 1'b0}); // JC taken
        va.push_back('{2, 0, 5'd21, 8'hFE, 1'b0, 1'b1}); // SUB r1,r1 -> 0
        va.push_back('{2, 0, 5'd22, 8'hFE, 1'b0, 1'b1}); // JC not taken
        va.push_back('{2, 0, 5'd10, 8'hFE, 1'b0, 1'b1}); // JZ taken
        va.push_back('{2, 0, 5'd11, 8'hFE, 1'b0, 1'b1}); // LDI r1,7
        va.push_back('{2, 0, 5'd12, 8'hFE, 1'b0, 1'b0}); // AND -> 5
        va.push_back('{2, 0, 5'd13, 8'hFE, 1'b0, 1'b0}); // JZ not taken
        va.push_back('{2, 0, 5'd14, 8'h05, 1'b0, 1'b0}); // OUT r1
        va.push_back('{6, 3, 5'd15, 8'h05, 1'b0, 1'b0}); // ST r2,9 (3 waits)
        va.push_back('{3, 0, 5'd16, 8'h05, 1'b0, 1'b0}); // LD r3,9 (no wait)
        va.push_back('{2, 0, 5'd17, 8'hA5, 1'b0, 1'b0}); // OUT r3
        va.push_back('{2, 0, 5'd24, 8'hA5, 1'b0, 1'b0}); // JMP 24
        va.push_back('{2, 0, 5'd25, 8'hA5, 1'b0, 1'b0}); // LDI r0,16
        va.push_back('{2, 0, 5'd26, 8'hA5, 1'b0, 1'b0}); // OR -> B5
        va.push_back('{2, 0, 5'd27, 8'hB5, 1'b0, 1'b0}); // OUT r0
        va.push_back('{2, 0, 5'd28, 8'hB5, 1'b1, 1'b0}); // ADD -> 6A, carry
        va.push_back('{2, 0, 5'd31, 8'hB5, 1'b1, 1'b0}); // JMP 31
        va.push_back('{2, 0, 5'd0,  8'hB5, 1'b1, 1'b0}); // NOP wraps to 0
        run_table();

        $display("store: req_cycles=%0d addr=%0d data=%02h", st_cycles, st_addr, st_data);
        chk("st_req_cycles", 32'(st_cycles), 32'd4);
        chk("st_addr",       32'(st_addr),   32'd9);
        chk("st_wdata",      32'(st_data),   32'h05);
        chk("st_pc_frozen",  32'(st_pc_bad), 32'd0);
        chk("ld_req_cycles", 32'(ld_cycles), 32'd1);

        // ---------------- program B: reserved op, CALL/RET or NOP, HALT ----------
        reset = 1'b1;
        clear_rom();
        rom[0] = enc(OP_LDI, 2'd1, 2'd0, 5'd9);
        rom[1] = enc(OP_RSV, 2'd1, 2'd0, 5'd7);
        rom[2] = enc(OP_OUT, 2'd1, 2'd0, 5'd0);
        rom[3] = enc(OP_CALL, 2'd0, 2'd0, 5'd12);
`ifdef K3_CALL_EN
        rom[12] = enc(OP_RET,  2'd0, 2'd0, 5'd0);
        rom[4]  = enc(OP_HALT, 2'd0, 2'd0, 5'd0);
        rom[5]  = enc(OP_OUT,  2'd0, 2'd0, 5'd0);
`else
        rom[4]  = enc(OP_RET,  2'd0, 2'd0, 5'd0);
        rom[5]  = enc(OP_HALT, 2'd0, 2'd0, 5'd0);
        rom[6]  = enc(OP_OUT,  2'd0, 2'd0, 5'd0);
`endif
        step(2);
        reset = 1'b0;
        va.delete();
        va.push_back('{2, 0, 5'd1,  8'h00, 1'b0, 1'b0}); // LDI r1,9
        va.push_back('{2, 0, 5'd2,  8'h00, 1'b0, 1'b0}); // reserved -> NOP
        va.push_back('{2, 0, 5'd3,  8'h09, 1'b0, 1'b0}); // OUT r1
`ifdef K3_CALL_EN
        va.push_back('{2, 0, 5'd12, 8'h09, 1'b0, 1'b0}); // CALL 12
        va.push_back('{2, 0, 5'd4,  8'h09, 1'b0, 1'b0}); // RET -> 4
        va.push_back('{2, 0, 5'd5,  8'h09, 1'b0, 1'b0}); // HALT
`else
        va.push_back('{2, 0, 5'd4,  8'h09, 1'b0, 1'b0}); // op13 as NOP
        va.push_back('{2, 0, 5'd5,  8'h09, 1'b0, 1'b0}); // op14 as NOP
        va.push_back('{2, 0, 5'd6,  8'h09, 1'b0, 1'b0}); // HALT
`endif
        run_table();
        chk("halt_flag", 32'(halted), 32'd1);
        step(10);
        $display("after 10 halted cycles: pc=%0d regO=%02h halted=%0b", romaddress, regO, halted);
`ifdef K3_CALL_EN
        chk("halt_pc_stable", 32'(romaddress), 32'd5);
`else
        chk("halt_pc_stable", 32'(romaddress), 32'd6);
`endif
        chk("halt_regO_stable", 32'(regO),    32'h09);
        chk("halt_still",       32'(halted),  32'd1);
        chk("halt_no_memreq",   32'(mem_req), 32'd0);

        // ---------------- program C: reset while a request is pending ------------
        reset = 1'b1;
        clear_rom();
        rom[1] = enc(OP_ST, 2'd0, 2'd0, 5'd3);
        ack_en = 1'b0;
        step(2);
        chk("rst_from_halt", 32'(halted), 32'd0);
        reset = 1'b0;
        step(4);
        $display("pending store: pc=%0d mem_req=%0b", romaddress, mem_req);
        chk("pend_req",  32'(mem_req),    32'd1);
        step(1);
        chk("pend_hold", 32'(mem_req),    32'd1);
        chk("pend_pc",   32'(romaddress), 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        $display("reset in MEM: pc=%0d mem_req=%0b", romaddress, mem_req);
        chk("rmem_req", 32'(mem_req),    32'd0);
        chk("rmem_pc",  32'(romaddress), 32'd0);
        step(1);
        chk("rmem_fetch_req", 32'(mem_req), 32'd0);
        step(1);
        chk("rmem_nop_pc", 32'(romaddress), 32'd1);
        step(2);
        chk("rmem_req_again", 32'(mem_req), 32'd1);
        ack_en   = 1'b1;
        mem_wait = 0;
        step(1);
        $display("store acked: pc=%0d mem_req=%0b", romaddress, mem_req);
        chk("rmem_ack_req", 32'(mem_req),    32'd0);
        chk("rmem_ack_pc",  32'(romaddress), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
